// File: rtl/deint_source_if.sv
// Avalon-ST video stream bundle (data/valid/ready/SOP/EOP) for the deinterlacer output.
interface deint_source_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  startofpacket;
    logic                  endofpacket;

    modport master (output data, valid, startofpacket, endofpacket, input ready);
    modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/deint_source.sv
// Bob/linear deinterlacer output stage: emits a progressive frame from two field-line FIFOs.
// Optional: define DEINT_AVG_ROUND_EN to round interpolated symbols half up instead of truncating.
module deint_source #(
    parameter int BPS         = 8,
    parameter int CHANNELS    = 3,
    parameter int WIDTH       = 720,
    parameter int HALF_HEIGHT = 288,
    parameter int DATA_WIDTH  = BPS * CHANNELS
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  rd_req0,
    input  logic [DATA_WIDTH-1:0] q0,
    output logic                  rd_req1,
    input  logic [DATA_WIDTH-1:0] q1,
    input  logic                  ready_to_continue,
    output logic                  aver_sent,
    deint_source_if.master        dout,
    output logic [3:0]            dbg_state
);
    typedef enum logic [3:0] {
        S_IDLE, S_CTRL, S_VHDR, S_ORIG, S_AVG, S_ACK, S_GAP, S_WAIT, S_TAIL
    } state_t;

    localparam int          AW        = $clog2(WIDTH);
    localparam logic [15:0] W16       = 16'(WIDTH);
    localparam logic [15:0] H16       = 16'(2 * HALF_HEIGHT);
    localparam logic [35:0] CTRL_NIBS = {W16, H16, 4'h0};
    localparam logic [9:0]  LAST_PIX  = 10'(WIDTH - 1);
    localparam logic [9:0]  LAST_PAIR = 10'(HALF_HEIGHT - 1);

    state_t                state_q, state_d;
    logic [9:0]            pix_q, pix_d;
    logic [9:0]            pair_q, pair_d;
    logic                  new_buf_q, new_buf_d;
    logic                  tail_pass_q, tail_pass_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;

    logic [DATA_WIDTH-1:0] line_ram [WIDTH];
    logic [DATA_WIDTH-1:0] prev_pix, new_head, beat_data, ram_wdata;
    logic                  can_load, issue, beat_sop, beat_eop, pop0, pop1, ram_we;
    logic                  pix_last;
    logic [9:0]            pix_inc;

    // Control packet beats 1..3: nibble i of {width, height, interlace} goes to the
    // low 4 bits of symbol (i mod CHANNELS), earliest nibble in the lowest symbol.
    function automatic logic [DATA_WIDTH-1:0] ctrl_beat(input logic [1:0] beat);
        logic [DATA_WIDTH-1:0] w;
        int idx;
        w = '0;
        for (int s = 0; s < CHANNELS; s++) begin
            idx = (int'(beat) - 1) * CHANNELS + s;
            if (idx >= 0 && idx < 9) w[s*BPS +: 4] = CTRL_NIBS[(8-idx)*4 +: 4];
        end
        return w;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] avg_pix(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        logic [BPS:0]          sum;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
`ifdef DEINT_AVG_ROUND_EN
            sum = {1'b0, a[c*BPS +: BPS]} + {1'b0, b[c*BPS +: BPS]} + {{BPS{1'b0}}, 1'b1};
`else
            sum = {1'b0, a[c*BPS +: BPS]} + {1'b0, b[c*BPS +: BPS]};
`endif
            r[c*BPS +: BPS] = sum[BPS:1];
        end
        return r;
    endfunction

    // Stream handshake: a beat moves when valid && ready; while valid && !ready the
    // output register holds data/SOP/EOP. A new beat (and its FIFO pop) is taken only
    // when the output register is empty or being drained this cycle.
    assign can_load = !valid_q || dout.ready;
    // Combinational read keeps the pixel path at one register of latency.
    assign prev_pix = line_ram[pix_q[AW-1:0]];
    assign new_head = new_buf_q ? q1 : q0;
    assign pix_last = (pix_q == LAST_PIX);
    assign pix_inc  = pix_q + 10'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pix_q       <= '0;
            pair_q      <= '0;
            new_buf_q   <= 1'b1;
            tail_pass_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            pair_q      <= pair_d;
            new_buf_q   <= new_buf_d;
            tail_pass_q <= tail_pass_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we) line_ram[pix_q[AW-1:0]] <= ram_wdata;
    end

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        pair_d      = pair_q;
        new_buf_d   = new_buf_q;
        tail_pass_d = tail_pass_q;
        case (state_q)
            S_IDLE: if (ready_to_continue && pair_q == '0) state_d = S_CTRL;
            S_CTRL: if (issue) begin
                if (pix_q == 10'd3) begin
                    pix_d   = '0;
                    state_d = S_VHDR;
                end else pix_d = pix_inc;
            end
            S_VHDR: if (issue) state_d = S_ORIG;
            S_ORIG: if (issue) begin
                pix_d = pix_last ? '0 : pix_inc;
                if (pix_last) state_d = S_AVG;
            end
            S_AVG: if (issue) begin
                pix_d = pix_last ? '0 : pix_inc;
                if (pix_last) state_d = S_ACK;
            end
            S_ACK: begin
                new_buf_d = !new_buf_q;
                pair_d    = pair_q + 10'd1;
                state_d   = S_GAP;
            end
            // The sink still holds ready_to_continue here; it is deliberately not sampled.
            S_GAP:  state_d = (pair_q < LAST_PAIR) ? S_WAIT : S_TAIL;
            S_WAIT: if (ready_to_continue) state_d = S_ORIG;
            S_TAIL: if (issue) begin
                pix_d = pix_last ? '0 : pix_inc;
                if (pix_last) begin
                    if (tail_pass_q) begin
                        tail_pass_d = 1'b0;
                        pair_d      = '0;
                        new_buf_d   = 1'b1;
                        state_d     = S_IDLE;
                    end else tail_pass_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue     = 1'b0;
        beat_data = '0;
        beat_sop  = 1'b0;
        beat_eop  = 1'b0;
        pop0      = 1'b0;
        pop1      = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = new_head;
        case (state_q)
            S_CTRL: begin
                issue     = can_load;
                beat_sop  = (pix_q == 10'd0);
                beat_eop  = (pix_q == 10'd3);
                beat_data = (pix_q == 10'd0) ? DATA_WIDTH'(4'hF) : ctrl_beat(pix_q[1:0]);
            end
            S_VHDR: begin
                issue    = can_load;
                beat_sop = 1'b1;
            end
            S_ORIG: begin
                issue = can_load;
                if (pair_q == '0) begin
                    beat_data = q0;
                    pop0      = can_load;
                    ram_we    = can_load;
                    ram_wdata = q0;
                end else beat_data = prev_pix;
            end
            S_AVG: begin
                issue     = can_load;
                beat_data = avg_pix(prev_pix, new_head);
                pop0      = can_load && !new_buf_q;
                pop1      = can_load && new_buf_q;
                ram_we    = can_load;
            end
            S_TAIL: begin
                issue     = can_load;
                beat_data = prev_pix;
                beat_eop  = tail_pass_q && pix_last;
            end
            default: ;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        valid_d = valid_q && !dout.ready;
        if (issue) begin
            data_d  = beat_data;
            sop_d   = beat_sop;
            eop_d   = beat_eop;
            valid_d = 1'b1;
        end
    end

    assign rd_req0            = pop0 && !reset;
    assign rd_req1            = pop1 && !reset;
    assign aver_sent          = (state_q == S_ACK);
    assign dout.data          = data_q;
    assign dout.valid         = valid_q;
    assign dout.startofpacket = sop_q;
    assign dout.endofpacket   = eop_q;
    assign dbg_state          = state_q;
endmodule
